pixel_stream_reader: RTL and testbench

//  Drains the RGB pixel FIFO filled by the image source and emits a framed valid/ready

---
 rtl/pixel_stream_reader_pkg.sv | 12 +
 rtl/pixel_stream_reader_if.sv | 22 ++
 rtl/pixel_stream_reader_skid_buf.sv | 51 +++++
 rtl/pixel_stream_reader.sv | 153 +++++++++++++++
 tb/tb_pixel_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_stream_reader_pkg.sv
// Shared types for the pixel stream reader: FSM encoding and checksum width.
package pixel_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } psr_state_e;

  localparam int CSUM_W = 32;

endpackage

// File: rtl/pixel_stream_reader_if.sv
// FIFO read port plus framed pixel output stream of the pixel stream reader.
interface pixel_stream_reader_if #(parameter int PIX_W = 96);
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_q;
  logic             fifo_rdreq;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;

  modport master (
    input  fifo_empty, fifo_q, out_ready,
    output fifo_rdreq, out_valid, out_data, out_sof, out_eol, out_eof
  );

  modport slave (
    output fifo_empty, fifo_q, out_ready,
    input  fifo_rdreq, out_valid, out_data, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/pixel_stream_reader_skid_buf.sv
// Registered output stage backed by two skid entries; absorbs FIFO words still
// in flight when the downstream stalls. skid_occ counts words behind the output.
module pixel_skid_buf #(
  parameter int W = 96
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   skid_occ
);
  logic [2:0][W-1:0] mem_q, mem_d;
  logic [1:0]        cnt_q, cnt_d, wr_idx;
  logic              pop;

  always_comb begin
    mem_d  = mem_q;
    pop    = (cnt_q != 2'd0) && out_ready;
    if (pop) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = mem_q[2];
    end
    // entry 0 is the output register; new words land just behind the survivors
    wr_idx = cnt_q - {1'b0, pop};
    if (in_valid) begin
      case (wr_idx)
        2'd0:    mem_d[0] = in_data;
        2'd1:    mem_d[1] = in_data;
        default: mem_d[2] = in_data;
      endcase
    end
    cnt_d = cnt_q + {1'b0, in_valid} - {1'b0, pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[0];
  assign skid_occ  = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
endmodule

// File: rtl/pixel_stream_reader.sv
// Drains the RGB pixel FIFO into a framed valid/ready stream (sof/eol/eof).
// Optional `define PSR_CHECKSUM_EN adds a running R+G+B checksum output.
module pixel_stream_reader
  import pixel_stream_reader_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DIM_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             cfg_start,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err,
`ifdef PSR_CHECKSUM_EN
  output logic [CSUM_W-1:0] checksum,
`endif
  pixel_stream_reader_if.master bus
);
  localparam int PIX_W = DWIDTH * 3;
  localparam int CNT_W = 2 * DIM_W;

  psr_state_e       state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] issued_q, issued_d, total;
  logic             inflight_q, inflight_d, cfg_err_q, cfg_err_d;
  logic             rdreq, beat, at_eol, at_eof;
  logic [1:0]       skid_occ;
  logic             sb_valid;
  logic [PIX_W-1:0] sb_data;
`ifdef PSR_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;

  function automatic logic [CSUM_W-1:0] pix_sum(input logic [PIX_W-1:0] p);
    return CSUM_W'(p[3*DWIDTH-1:2*DWIDTH]) + CSUM_W'(p[2*DWIDTH-1:DWIDTH])
         + CSUM_W'(p[DWIDTH-1:0]);
  endfunction
`endif

  pixel_skid_buf #(.W(PIX_W)) u_skid (
    .clock, .reset,
    .in_valid (inflight_q),
    .in_data  (bus.fifo_q),
    .out_valid(sb_valid),
    .out_ready(bus.out_ready),
    .out_data (sb_data),
    .skid_occ
  );

  always_comb begin
    total  = CNT_W'(w_q) * CNT_W'(h_q);
    at_eol = (x_q == w_q - DIM_W'(1));
    at_eof = at_eol && (y_q == h_q - DIM_W'(1));
    beat   = sb_valid && bus.out_ready;
    // only register-fed terms: every issued word must fit behind the output stage
    rdreq  = (state_q == ST_RUN) && !bus.fifo_empty
          && (({1'b0, skid_occ} + {2'b0, inflight_q}) < 3'd2)
          && (issued_q < total);
  end

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    x_d        = x_q;
    y_d        = y_q;
    issued_d   = issued_q;
    inflight_d = rdreq;
    cfg_err_d  = 1'b0;
`ifdef PSR_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_width != '0 && cfg_height != '0) begin
            state_d  = ST_RUN;
            w_d      = cfg_width;
            h_d      = cfg_height;
            x_d      = '0;
            y_d      = '0;
            issued_d = '0;
`ifdef PSR_CHECKSUM_EN
            csum_d   = '0;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rdreq) issued_d = issued_q + CNT_W'(1);
        if (beat) begin
`ifdef PSR_CHECKSUM_EN
          csum_d = csum_q + pix_sum(sb_data);
`endif
          if (at_eol) begin
            x_d = '0;
            y_d = y_q + DIM_W'(1);
          end else begin
            x_d = x_q + DIM_W'(1);
          end
          if (at_eof) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef PSR_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      h_q        <= h_d;
      x_q        <= x_d;
      y_q        <= y_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      cfg_err_q  <= cfg_err_d;
`ifdef PSR_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_DONE);
  assign cfg_err        = cfg_err_q;
  assign bus.fifo_rdreq = rdreq;
  assign bus.out_valid  = sb_valid;
  assign bus.out_data   = sb_data;
  assign bus.out_sof    = sb_valid && (x_q == '0) && (y_q == '0);
  assign bus.out_eol    = sb_valid && at_eol;
  assign bus.out_eof    = sb_valid && at_eof;
`ifdef PSR_CHECKSUM_EN
  assign checksum       = csum_q;
`endif
endmodule

// File: tb/tb_pixel_stream_reader.sv
// Directed bench for pixel_stream_reader: FIFO model, expected-beat queue built
// from frame geometry, and a per-cycle compare process on the output stream.
module tb_pixel_stream_reader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_width = '0, cfg_height = '0;
  logic        cfg_start = 1'b0;
  logic        busy, frame_done, cfg_err;
`ifdef PSR_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  pixel_stream_reader_if #(.PIX_W(96)) bus ();

  pixel_stream_reader #(.DWIDTH(32), .DIM_W(16)) dut (
    .clock(clock), .reset(reset),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_start(cfg_start),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
`ifdef PSR_CHECKSUM_EN
    .checksum(checksum),
`endif
    .bus(bus)
  );

  typedef struct { logic [95:0] d; logic sof, eol, eof; } beat_t;

  beat_t       exp_q[$];
  logic [95:0] pend[$], fifo_mem[$];
  int          rd_cyc[$], beat_cyc[$], done_cyc[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0, outstanding = 0, acc_cnt = 0;
  int          first_valid = -1, sof_cnt = 0, eol_cnt = 0, eof_cnt = 0;
  logic        first_sof = 1'b0;
  logic [95:0] first_data = '0;
  int          ready_mode = 0;
  logic        tog = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO with one-cycle read latency
  always @(posedge clock) begin
    if (bus.fifo_rdreq === 1'b1 && fifo_mem.size() != 0) bus.fifo_q <= fifo_mem.pop_front();
    bus.fifo_empty <= (fifo_mem.size() == 0);
  end

  always @(posedge clock) begin
    #1;
    if (ready_mode == 0) bus.out_ready = 1'b1;
    else begin
      bus.out_ready = tog;
      tog = ~tog;
    end
  end

  // compare process
  always @(negedge clock) begin
    beat_t e;
    if (reset) outstanding = 0;
    else begin
      if (bus.fifo_rdreq === 1'b1) begin
        chk("rdreq_credit", outstanding <= 2, 1'b1);
        chk("rdreq_nonempty", bus.fifo_empty, 1'b0);
        rd_cyc.push_back(cyc);
        outstanding++;
      end
      if (bus.out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) chk("extra_beat", 1'b1, 1'b0);
        else begin
          e = exp_q[0];
          chk("beat_data", bus.out_data, e.d);
          chk("beat_flags", {bus.out_sof, bus.out_eol, bus.out_eof}, {e.sof, e.eol, e.eof});
          if (bus.out_ready === 1'b1) begin
            void'(exp_q.pop_front());
            if (beat_cyc.size() == 0) begin
              first_sof  = bus.out_sof;
              first_data = bus.out_data;
            end
            beat_cyc.push_back(cyc);
            acc_cnt++;
            outstanding--;
            sof_cnt += int'(bus.out_sof);
            eol_cnt += int'(bus.out_eol);
            eof_cnt += int'(bus.out_eof);
          end
        end
      end
      if (frame_done === 1'b1) done_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic gen(input int n, input int seed);
    for (int i = 0; i < n; i++)
      pend.push_back({32'(seed * 100 + i), 32'(i * 7 + 1), 32'hA5A5_0000 + 32'(i)});
  endtask

  // expected beats from geometry: pixel i is eol when i%w==w-1
  task automatic build_exp(input int w, input int h);
    beat_t b;
    for (int i = 0; i < w * h; i++) begin
      b.d   = pend[i];
      b.sof = (i == 0);
      b.eol = ((i % w) == w - 1);
      b.eof = (i == w * h - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic feed(input int k);
    for (int i = 0; i < k; i++) if (pend.size() != 0) fifo_mem.push_back(pend.pop_front());
  endtask

  task automatic clear_rec();
    rd_cyc.delete(); beat_cyc.delete(); done_cyc.delete();
    acc_cnt = 0; first_valid = -1; sof_cnt = 0; eol_cnt = 0; eof_cnt = 0;
  endtask

  task automatic start(input int w, input int h);
    cfg_width  = 16'(w);
    cfg_height = 16'(h);
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    logic got = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clock);
      if (frame_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, got, 1'b1);
  endtask

  task automatic check_zero(input string name);
    chk(name, {busy, frame_done, cfg_err, bus.fifo_rdreq, bus.out_valid,
               bus.out_sof, bus.out_eol, bus.out_eof}, 8'h00);
    chk({name, "_data"}, bus.out_data, 96'h0);
`ifdef PSR_CHECKSUM_EN
    chk({name, "_csum"}, checksum, 32'h0);
`endif
  endtask

  initial begin
    logic got;
    repeat (3) tick();
    check_zero("reset_state");
    reset = 1'b0;
    tick();

    // 1: 4x2 frame, ready held high
    clear_rec(); gen(8, 1); build_exp(4, 2); feed(8); tick();
    start(4, 2);
    wait_done("t1_done", 60);
    chk("t1_exp_left", exp_q.size(), 0);
    chk("t1_beats", beat_cyc.size(), 8);
    chk("t1_rdreqs", rd_cyc.size(), 8);
    chk("t1_sof_cnt", sof_cnt, 1);
    chk("t1_eol_cnt", eol_cnt, 2);
    chk("t1_eof_cnt", eof_cnt, 1);
    chk("t1_first_pix", first_data, {32'd100, 32'd1, 32'hA5A5_0000});
    if (beat_cyc.size() == 8 && done_cyc.size() != 0 && rd_cyc.size() != 0) begin
      chk("t1_back_to_back", beat_cyc[7] - beat_cyc[0], 7);
      chk("t1_done_cycle", done_cyc[0], beat_cyc[7] + 1);
      chk("t1_latency", first_valid - rd_cyc[0], 2);
    end
    tick();
    chk("t1_idle_busy", busy, 1'b0);

    // 2: same frame, ready toggling 1010...
    clear_rec(); gen(8, 2); build_exp(4, 2); feed(8); tick();
    tog = 1'b1; ready_mode = 1;
    start(4, 2);
    wait_done("t2_done", 100);
    ready_mode = 0;
    chk("t2_exp_left", exp_q.size(), 0);
    chk("t2_beats", beat_cyc.size(), 8);
    chk("t2_rdreqs", rd_cyc.size(), 8);
    tick();

    // 3: 4x1 frame, FIFO runs dry after 3 words
    clear_rec(); gen(4, 3); build_exp(4, 1); feed(3); tick();
    start(4, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_busy_gap", busy, 1'b1);
    end
    chk("t3_rd_before_refill", rd_cyc.size(), 3);
    chk("t3_beats_before_refill", acc_cnt, 3);
    feed(1);
    wait_done("t3_done", 30);
    chk("t3_rdreqs", rd_cyc.size(), 4);
    chk("t3_exp_left", exp_q.size(), 0);
    chk("t3_eol_eof", {eol_cnt[1:0], eof_cnt[1:0]}, 4'b0101);
    tick();

    // 4: zero dimensions rejected
    for (int c = 0; c < 2; c++) begin
      clear_rec();
      fifo_mem.push_back(96'h1); fifo_mem.push_back(96'h2);
      tick();
      if (c == 0) start(0, 3); else start(5, 0);
      @(negedge clock);
      chk("t4_err_pulse", {cfg_err, busy}, 2'b10);
      @(negedge clock);
      chk("t4_err_clear", cfg_err, 1'b0);
      repeat (3) @(negedge clock);
      chk("t4_no_rdreq", rd_cyc.size(), 0);
      chk("t4_busy", busy, 1'b0);
      tick();
      fifo_mem.delete();
      tick();
    end

    // 5: reset while beat 2 of a 4x4 frame is presented
    clear_rec(); gen(16, 5); build_exp(4, 4); feed(16); tick();
    start(4, 4);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (acc_cnt >= 2) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("t5_reach_beat2", got, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    tick();
    check_zero("t5_reset");
    reset = 1'b0;
    fifo_mem.delete(); pend.delete();
    tick(); tick();
    clear_rec(); gen(2, 6); build_exp(2, 1); feed(2); tick();
    start(2, 1);
    wait_done("t5_restart_done", 30);
    chk("t5_first_sof", first_sof, 1'b1);
    chk("t5_exp_left", exp_q.size(), 0);
    tick();

`ifdef PSR_CHECKSUM_EN
    // 6: checksum wraps modulo 2^32
    clear_rec();
    pend.push_back({32'd1, 32'd2, 32'd3});
    pend.push_back({32'hFFFF_FFFF, 32'd1, 32'd0});
    build_exp(2, 1); feed(2); tick();
    start(2, 1);
    chk("t6_csum_cleared", checksum, 32'h0);
    wait_done("t6_done", 30);
    chk("t6_checksum", checksum, 32'h6);
    repeat (3) tick();
    chk("t6_checksum_held", checksum, 32'h6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
